// File: rtl/shift_reg_univ.sv
// shift_reg_univ: parametrised N-bit universal shift register.
//
// Each rising edge applies one operation, chosen by mode, to the register q.
// The operations are hold, parallel load, logical shift left/right with a
// serial fill bit, rotate left/right, arithmetic shift right, and clear.
// This is the storage and serialisation building block for serial links,
// LFSR front-ends and shift-and-add multipliers.
//
// Parameters:
//   NBITS        register width in bits (1 or more)
//   RESET_VALUE  value loaded into q by rst
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-high; highest priority
//   en        update enable; 0 holds q whatever mode is
//   mode      operation select (see mode_t below)
//   d         parallel load data
//   sin       serial fill bit, used only by SHL and SHR
//   q         register contents
//   sout_msb  q[NBITS-1], the bit a left shift discards
//   sout_lsb  q[0], the bit a right shift discards
module shift_reg_univ #(
    parameter int               NBITS       = 8,
    parameter logic [NBITS-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [NBITS-1:0] d,
    input  logic             sin,
    output logic [NBITS-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb
);

    typedef enum logic [2:0] {
        MODE_HOLD = 3'b000,
        MODE_LOAD = 3'b001,
        MODE_SHL  = 3'b010,
        MODE_SHR  = 3'b011,
        MODE_ROL  = 3'b100,
        MODE_ROR  = 3'b101,
        MODE_ASR  = 3'b110,
        MODE_CLR  = 3'b111
    } mode_t;

    logic [NBITS-1:0] shl_val;
    logic [NBITS-1:0] shr_val;
    logic [NBITS-1:0] rol_val;
    logic [NBITS-1:0] ror_val;
    logic [NBITS-1:0] asr_val;
    logic [NBITS-1:0] next_q;

    // The shifted candidates are built in a generate so a one-bit register
    // never elaborates the q[NBITS-2:0] style slices, which would have a
    // negative width. With one bit, a logical shift just loads sin, and a
    // rotate or arithmetic shift leaves the bit where it is.
    generate
        if (NBITS == 1) begin : g_narrow
            assign shl_val = sin;
            assign shr_val = sin;
            assign rol_val = q;
            assign ror_val = q;
            assign asr_val = q;
        end else begin : g_wide
            assign shl_val = {q[NBITS-2:0], sin};
            assign shr_val = {sin, q[NBITS-1:1]};
            assign rol_val = {q[NBITS-2:0], q[NBITS-1]};
            assign ror_val = {q[0], q[NBITS-1:1]};
            assign asr_val = {q[NBITS-1], q[NBITS-1:1]};
        end
    endgenerate

    // Choose the next register value from the mode code. All eight codes are
    // listed explicitly. The default only catches X or Z codes, and it drives X
    // so that a bad mode shows up in q during simulation instead of being
    // quietly treated as a hold.
    always_comb begin
        next_q = q;
        case (mode)
            MODE_HOLD: next_q = q;
            MODE_LOAD: next_q = d;
            MODE_SHL:  next_q = shl_val;
            MODE_SHR:  next_q = shr_val;
            MODE_ROL:  next_q = rol_val;
            MODE_ROR:  next_q = ror_val;
            MODE_ASR:  next_q = asr_val;
            MODE_CLR:  next_q = '0;
            default:   next_q = 'x;
        endcase
    end

    // State register. rst wins over everything. en=0 holds q. Otherwise the
    // mode-selected value is taken. CLR goes to zero, not to RESET_VALUE,
    // so clear and reset stay distinguishable.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= next_q;
        end
    end

    // The serial outputs are plain taps on q. They have no path from d, sin
    // or mode.
    assign sout_msb = q[NBITS-1];
    assign sout_lsb = q[0];

endmodule
